// File: rtl/aes_key_pkg.sv
// AES-128 key schedule shared types, constants and byte helpers.
// Used by the inverse round-key streamer and its expand round.
package aes_key_pkg;

  localparam int NR    = 10;
  localparam int KEY_W = 128;

  localparam logic [3:0] RD_TOP = 4'(NR);
  localparam logic [3:0] CNT_END = 4'(NR - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    SERVE
  } state_t;

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] rcon(
    input logic [3:0] rc
  );
    return (rc < 4'd10) ? RCON[rc] : 8'h00;
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the GF(2^8) inverse (0 maps to 0)
  function automatic logic [7:0] ginv(
    input logic [7:0] a
  );
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] a
  );
    logic [7:0] b;
    b = ginv(a);
    return b
      ^ {b[6:0], b[7]}
      ^ {b[5:0], b[7:6]}
      ^ {b[4:0], b[7:5]}
      ^ {b[3:0], b[7:4]}
      ^ 8'h63;
  endfunction

endpackage

// File: rtl/key_expand_round.sv
// One AES-128 key expansion step, purely combinational.
// rc selects the round constant; rc=0 yields the round-1 key.
module key_expand_round
  import aes_key_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  input  logic [3:0]       rc,
  output logic [KEY_W-1:0] nxt
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;

  // RotWord, SubWord, Rcon, then the word chain
  always_comb begin
    {w0, w1, w2, w3} = key;
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]),
           sbox(rot[15:8]),  sbox(rot[7:0])};
    t   = sub ^ {rcon(rc), 24'h0};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    nxt = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/inv_key_schedule.sv
// Sequential AES-128 expander streaming round keys 10 down to 0.
// Optional INV_KEY_CACHE_EN reuses the buffer for a repeated key.
module inv_key_schedule
  import aes_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key_in,
  input  logic             flush,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] rk_data,
  output logic [3:0]       rk_round,
  output logic             rk_last
);

  state_t state_q, state_n;

  logic [3:0]       cnt_q, cnt_n;
  logic [3:0]       ptr_q, ptr_n;
  logic [KEY_W-1:0] kbuf [NR+1];
  logic [KEY_W-1:0] exp_out;
  logic [KEY_W-1:0] data_n;
  logic [3:0]       round_n;
  logic             valid_n;
  logic             last_n;
  logic             wr_en;
  logic [3:0]       wr_idx;
  logic [KEY_W-1:0] wr_data;
  logic             take;
  logic             hit;

  key_expand_round u_round (
    .key (kbuf[cnt_q]),
    .rc  (cnt_q),
    .nxt (exp_out)
  );

  assign key_ready = (state_q == IDLE);
  assign take      = key_valid & key_ready;

`ifdef INV_KEY_CACHE_EN
  logic [KEY_W-1:0] tag_q;
  logic             tag_v;
  logic             fill;

  assign hit  = tag_v & (key_in == tag_q);
  assign fill = (state_q == EXPAND)
              & (cnt_q == CNT_END)
              & ~flush;

  // remember the key whose expansion is resident
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
      tag_v <= 1'b0;
    end else if (flush) begin
      tag_v <= 1'b0;
    end else if (fill) begin
      tag_q <= kbuf[0];
      tag_v <= 1'b1;
    end else if (take & ~hit) begin
      tag_v <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // next state, counters, buffer write and output staging
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    ptr_n   = ptr_q;
    valid_n = rk_valid;
    last_n  = rk_last;
    data_n  = rk_data;
    round_n = rk_round;
    wr_en   = 1'b0;
    wr_idx  = cnt_q + 4'd1;
    wr_data = exp_out;
    if (flush) begin
      state_n = IDLE;
      cnt_n   = '0;
      valid_n = 1'b0;
      last_n  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (take && hit) begin
            state_n = SERVE;
            ptr_n   = RD_TOP;
            valid_n = 1'b1;
            data_n  = kbuf[RD_TOP];
            round_n = RD_TOP;
            last_n  = 1'b0;
          end else if (take) begin
            state_n = EXPAND;
            cnt_n   = '0;
            wr_en   = 1'b1;
            wr_idx  = '0;
            wr_data = key_in;
          end
        end
        EXPAND: begin
          wr_en = 1'b1;
          if (cnt_q == CNT_END) begin
            state_n = SERVE;
            cnt_n   = '0;
            ptr_n   = RD_TOP;
            valid_n = 1'b1;
            data_n  = exp_out;
            round_n = RD_TOP;
            last_n  = 1'b0;
          end else begin
            cnt_n = cnt_q + 4'd1;
          end
        end
        SERVE: begin
          if (rk_ready && ptr_q == 4'd0) begin
            state_n = IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
          end else if (rk_ready) begin
            ptr_n   = ptr_q - 4'd1;
            data_n  = kbuf[ptr_n];
            round_n = ptr_n;
            last_n  = (ptr_n == 4'd0);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
      rk_data  <= '0;
      rk_round <= '0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      ptr_q    <= ptr_n;
      rk_valid <= valid_n;
      rk_last  <= last_n;
      rk_data  <= data_n;
      rk_round <= round_n;
    end
  end

  // round-key storage, contents irrelevant until written
  always_ff @(posedge clk) begin
    if (wr_en) kbuf[wr_idx] <= wr_data;
  end

endmodule
